// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryption engine: FSM state encoding,
// S-box size and the printable-text range used by the optional ASCII check
// (enabled with RC4_ASCII_CHECK_EN).
package rc4_pkg;

   localparam int         RC4_N    = 256;
   localparam logic [7:0] ASCII_LO = 8'h61;
   localparam logic [7:0] ASCII_HI = 8'h7A;
   localparam logic [7:0] ASCII_SP = 8'h20;

   // KSA and PRGA share the swap states; a phase flag in the engine tells them apart
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_RD_I,
      ST_GET_I,
      ST_RD_J,
      ST_GET_J,
      ST_WR_I,
      ST_WR_J,
      ST_RD_F,
      ST_GET_F,
      ST_WR_D,
      ST_DONE
   } rc4_state_e;

   // Lower-case letters and space count as valid plaintext
   function automatic logic is_text(input logic [7:0] b);
      return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
   endfunction

endpackage

// File: rtl/rc4_key_mux.sv
// Selects the current key byte from the packed key register.
// Byte 0 of the key is the most significant byte of key_i.
module rc4_key_mux
   import rc4_pkg::*;
#(
   parameter  int KEY_BYTES = 3,
   localparam int KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
   input  logic [8*KEY_BYTES-1:0] key_i,
   input  logic [KIW-1:0]         idx_i,
   output logic [7:0]             byte_o
);

   // One-hot compare against every legal index; out-of-range indices yield 0
   always_comb begin
      byte_o = 8'h00;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (idx_i == KIW'(b)) begin
            byte_o = key_i[8*(KEY_BYTES-1-b) +: 8];
         end
      end
   end

endmodule

// File: rtl/rc4_engine.sv
// RC4 decryption engine: S-box init, key scheduling and keystream/decrypt
// of MSG_LEN bytes from the encrypted ROM into the result RAM.
// Optional feature macro: RC4_ASCII_CHECK_EN (abort on non-text plaintext).
module rc4_engine
   import rc4_pkg::*;
#(
   parameter  int KEY_BYTES = 3,
   parameter  int MSG_LEN   = 32,
   localparam int AW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
   localparam int KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [7:0]             s_addr,
   output logic [7:0]             s_wdata,
   output logic                   s_wren,
   input  logic [7:0]             s_rdata,
   output logic [AW-1:0]          rom_addr,
   input  logic [7:0]             rom_rdata,
   output logic [AW-1:0]          d_addr,
   output logic [7:0]             d_wdata,
   output logic                   d_wren
);

   rc4_state_e             state_q, state_d;
   logic                   fail_q, fail_d;
   logic                   prga_q, prga_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic [7:0]             i_q, i_d;
   logic [7:0]             j_q, j_d;
   logic [7:0]             si_q, si_d;
   logic [7:0]             sj_q, sj_d;
   logic [7:0]             pt_q, pt_d;
   logic [AW-1:0]          k_q, k_d;
   logic [KIW-1:0]         kidx_q, kidx_d;
   logic [7:0]             key_byte;

   rc4_key_mux #(
      .KEY_BYTES (KEY_BYTES)
   ) u_key_mux (
      .key_i  (key_q),
      .idx_i  (kidx_q),
      .byte_o (key_byte)
   );

   // Control state: the only registers that reset clears
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
      end
   end

   // Datapath registers; every run reinitialises them when start is accepted
   always_ff @(posedge clk) begin
      prga_q <= prga_d;
      key_q  <= key_d;
      i_q    <= i_d;
      j_q    <= j_d;
      si_q   <= si_d;
      sj_q   <= sj_d;
      pt_q   <= pt_d;
      k_q    <= k_d;
      kidx_q <= kidx_d;
   end

   // Next-state and memory-port decode; outputs are zero outside active states
   always_comb begin
      state_d  = state_q;
      fail_d   = fail_q;
      prga_d   = prga_q;
      key_d    = key_q;
      i_d      = i_q;
      j_d      = j_q;
      si_d     = si_q;
      sj_d     = sj_q;
      pt_d     = pt_q;
      k_d      = k_q;
      kidx_d   = kidx_q;
      busy     = 1'b1;
      s_addr   = 8'h00;
      s_wdata  = 8'h00;
      s_wren   = 1'b0;
      rom_addr = '0;
      d_addr   = '0;
      d_wdata  = 8'h00;
      d_wren   = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            busy = 1'b0;
            if (start) begin
               key_d   = key;
               i_d     = 8'h00;
               j_d     = 8'h00;
               k_d     = '0;
               kidx_d  = '0;
               prga_d  = 1'b0;
               fail_d  = 1'b0;
               state_d = ST_INIT;
            end
         end

         ST_INIT: begin
            s_addr  = i_q;
            s_wdata = i_q;
            s_wren  = 1'b1;
            i_d     = i_q + 8'd1;
            if (i_q == 8'(RC4_N - 1)) begin
               state_d = ST_RD_I;
            end
         end

         ST_RD_I: begin
            // Keystream generation pre-increments i before reading S[i]
            if (prga_q) begin
               i_d    = i_q + 8'd1;
               s_addr = i_q + 8'd1;
            end else begin
               s_addr = i_q;
            end
            state_d = ST_GET_I;
         end

         ST_GET_I: begin
            si_d = s_rdata;
            if (prga_q) begin
               j_d = j_q + s_rdata;
            end else begin
               j_d    = j_q + s_rdata + key_byte;
               kidx_d = (kidx_q == KIW'(KEY_BYTES - 1)) ? '0 : kidx_q + KIW'(1);
            end
            state_d = ST_RD_J;
         end

         ST_RD_J: begin
            s_addr  = j_q;
            state_d = ST_GET_J;
         end

         ST_GET_J: begin
            sj_d    = s_rdata;
            state_d = ST_WR_I;
         end

         ST_WR_I: begin
            s_addr  = i_q;
            s_wdata = sj_q;
            s_wren  = 1'b1;
            state_d = ST_WR_J;
         end

         ST_WR_J: begin
            // When i==j both writes target one address with the same value
            s_addr  = j_q;
            s_wdata = si_q;
            s_wren  = 1'b1;
            if (prga_q) begin
               state_d = ST_RD_F;
            end else if (i_q == 8'(RC4_N - 1)) begin
               i_d     = 8'h00;
               j_d     = 8'h00;
               prga_d  = 1'b1;
               state_d = ST_RD_I;
            end else begin
               i_d     = i_q + 8'd1;
               state_d = ST_RD_I;
            end
         end

         ST_RD_F: begin
            s_addr   = si_q + sj_q;
            rom_addr = k_q;
            state_d  = ST_GET_F;
         end

         ST_GET_F: begin
            pt_d    = s_rdata ^ rom_rdata;
            state_d = ST_GET_F == state_q ? ST_WR_D : state_q;
         end

         ST_WR_D: begin
            d_addr  = k_q;
            d_wdata = pt_q;
            d_wren  = 1'b1;
`ifdef RC4_ASCII_CHECK_EN
            if (!is_text(pt_q)) begin
               d_wren  = 1'b0;
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end else if (k_q == AW'(MSG_LEN - 1)) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + AW'(1);
               state_d = ST_RD_I;
            end
`else
            if (k_q == AW'(MSG_LEN - 1)) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + AW'(1);
               state_d = ST_RD_I;
            end
`endif
         end

         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign done = (state_q == ST_DONE);
   assign fail = fail_q;

endmodule

// File: tb/tb_rc4_engine.sv
// Self-checking bench for rc4_engine using the published RC4 test vectors
// ("Key"/"Plaintext" and "Wiki"/"pedia") on two parameterisations.
module tb_rc4_engine;

   typedef struct {
      logic [7:0] ct;
      logic [7:0] pt;
   } vec_t;

`ifdef RC4_ASCII_CHECK_EN
   localparam int A_DONE = 1802;
   localparam int A_WR   = 0;
   localparam int A_FAIL = 1;
`else
   localparam int A_DONE = 1874;
   localparam int A_WR   = 9;
   localparam int A_FAIL = 0;
`endif
   localparam int B_DONE = 1838;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   vec_t va [9];
   vec_t vb [5];

   // ---------------- instance A: KEY_BYTES=3, MSG_LEN=9 ----------------
   logic        start_a;
   logic [23:0] key_a;
   logic        busy_a, done_a, fail_a;
   logic [7:0]  s_addr_a, s_wdata_a, s_rdata_a;
   logic        s_wren_a;
   logic [3:0]  rom_addr_a, d_addr_a;
   logic [7:0]  rom_rdata_a, d_wdata_a;
   logic        d_wren_a;
   logic [7:0]  smem_a [256];
   logic [7:0]  rom_a  [16];
   logic [7:0]  dmem_a [16];
   int          sw_a = 0;
   int          dw_a = 0;
   logic        clr_a;

   rc4_engine #(.KEY_BYTES(3), .MSG_LEN(9)) u_a (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start_a),
      .key       (key_a),
      .busy      (busy_a),
      .done      (done_a),
      .fail      (fail_a),
      .s_addr    (s_addr_a),
      .s_wdata   (s_wdata_a),
      .s_wren    (s_wren_a),
      .s_rdata   (s_rdata_a),
      .rom_addr  (rom_addr_a),
      .rom_rdata (rom_rdata_a),
      .d_addr    (d_addr_a),
      .d_wdata   (d_wdata_a),
      .d_wren    (d_wren_a)
   );

   always @(posedge clk) begin
      s_rdata_a   <= smem_a[s_addr_a];
      rom_rdata_a <= rom_a[rom_addr_a];
      if (s_wren_a) begin
         smem_a[s_addr_a] <= s_wdata_a;
         sw_a <= sw_a + 1;
      end
      if (clr_a) begin
         for (int x = 0; x < 16; x++) dmem_a[x] <= 8'h00;
      end else if (d_wren_a) begin
         dmem_a[d_addr_a] <= d_wdata_a;
         dw_a <= dw_a + 1;
      end
   end

   // ---------------- instance B: KEY_BYTES=4, MSG_LEN=5 ----------------
   logic        start_b;
   logic [31:0] key_b;
   logic        busy_b, done_b, fail_b;
   logic [7:0]  s_addr_b, s_wdata_b, s_rdata_b;
   logic        s_wren_b;
   logic [2:0]  rom_addr_b, d_addr_b;
   logic [7:0]  rom_rdata_b, d_wdata_b;
   logic        d_wren_b;
   logic [7:0]  smem_b [256];
   logic [7:0]  rom_b  [8];
   logic [7:0]  dmem_b [8];
   int          dw_b = 0;
   logic        clr_b;

   rc4_engine #(.KEY_BYTES(4), .MSG_LEN(5)) u_b (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start_b),
      .key       (key_b),
      .busy      (busy_b),
      .done      (done_b),
      .fail      (fail_b),
      .s_addr    (s_addr_b),
      .s_wdata   (s_wdata_b),
      .s_wren    (s_wren_b),
      .s_rdata   (s_rdata_b),
      .rom_addr  (rom_addr_b),
      .rom_rdata (rom_rdata_b),
      .d_addr    (d_addr_b),
      .d_wdata   (d_wdata_b),
      .d_wren    (d_wren_b)
   );

   always @(posedge clk) begin
      s_rdata_b   <= smem_b[s_addr_b];
      rom_rdata_b <= rom_b[rom_addr_b];
      if (s_wren_b) smem_b[s_addr_b] <= s_wdata_b;
      if (clr_b) begin
         for (int x = 0; x < 8; x++) dmem_b[x] <= 8'h00;
      end else if (d_wren_b) begin
         dmem_b[d_addr_b] <= d_wdata_b;
         dw_b <= dw_b + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic launch_a(input logic [23:0] k);
      key_a   = k;
      start_a = 1'b1;
      cyc     = 0;
      step();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a();
      while (!done_a && cyc < 4000) step();
      chk("done_a_reached", {31'd0, done_a}, 32'd1);
   endtask

   task automatic clear_a();
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
   endtask

   // Full result check for instance A after a run of the "Key" vector
   task automatic check_a(input int dw0, input string tag);
      chk({tag, "_done_cycle"}, cyc, A_DONE);
      chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
      chk({tag, "_fail"}, {31'd0, fail_a}, A_FAIL);
      chk({tag, "_dwrites"}, dw_a - dw0, A_WR);
      for (int n = 0; n < 9; n++) begin
`ifdef RC4_ASCII_CHECK_EN
         chk($sformatf("%s_d[%0d]", tag, n), {24'd0, dmem_a[n]}, 32'h00);
`else
         chk($sformatf("%s_d[%0d]", tag, n), {24'd0, dmem_a[n]}, {24'd0, va[n].pt});
`endif
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int sw0, dw0, errs;

      va[0] = '{8'hBB, 8'h50}; va[1] = '{8'hF3, 8'h6C}; va[2] = '{8'h16, 8'h61};
      va[3] = '{8'hE8, 8'h69}; va[4] = '{8'hD9, 8'h6E}; va[5] = '{8'h40, 8'h74};
      va[6] = '{8'hAF, 8'h65}; va[7] = '{8'h0A, 8'h78}; va[8] = '{8'hD3, 8'h74};
      vb[0] = '{8'h10, 8'h70}; vb[1] = '{8'h21, 8'h65}; vb[2] = '{8'hBF, 8'h64};
      vb[3] = '{8'h04, 8'h69}; vb[4] = '{8'h20, 8'h61};
      for (int n = 0; n < 16; n++) rom_a[n] = (n < 9) ? va[n].ct : 8'h00;
      for (int n = 0; n < 8; n++)  rom_b[n] = (n < 5) ? vb[n].ct : 8'h00;

      reset_n = 1'b0;
      start_a = 1'b0; key_a = '0; clr_a = 1'b1;
      start_b = 1'b0; key_b = '0; clr_b = 1'b1;
      repeat (3) step();
      chk("rst_busy",   {31'd0, busy_a},   32'd0);
      chk("rst_done",   {31'd0, done_a},   32'd0);
      chk("rst_fail",   {31'd0, fail_a},   32'd0);
      chk("rst_s_wren", {31'd0, s_wren_a}, 32'd0);
      chk("rst_d_wren", {31'd0, d_wren_a}, 32'd0);
      chk("rst_s_addr", {24'd0, s_addr_a}, 32'd0);
      reset_n = 1'b1;
      clr_a = 1'b0;
      clr_b = 1'b0;
      step();

      // Run 1: stop after INIT to inspect S, then finish the "Key" vector
      sw0 = sw_a;
      dw0 = dw_a;
      launch_a(24'h4B6579);
      chk("run1_busy_c1", {31'd0, busy_a}, 32'd1);
      chk("run1_done_c1", {31'd0, done_a}, 32'd0);
      run_to(257);
      chk("init_swrites", sw_a - sw0, 32'd256);
      errs = 0;
      for (int n = 0; n < 256; n++) if (smem_a[n] !== 8'(n)) errs++;
      chk("init_identity_errs", errs, 32'd0);
      chk("init_busy", {31'd0, busy_a}, 32'd1);
      wait_done_a();
      check_a(dw0, "run1");
      repeat (3) step();
      chk("done_held", {31'd0, done_a}, 32'd1);

      // Run 2: reset in the middle of key scheduling
      clear_a();
      launch_a(24'h4B6579);
      chk("run2_done_cleared", {31'd0, done_a}, 32'd0);
      chk("run2_busy", {31'd0, busy_a}, 32'd1);
      run_to(600);
      reset_n = 1'b0;
      step();
      sw0 = sw_a;
      dw0 = dw_a;
      chk("midrst_busy",   {31'd0, busy_a},   32'd0);
      chk("midrst_s_wren", {31'd0, s_wren_a}, 32'd0);
      repeat (3) step();
      chk("midrst_no_swrites", sw_a - sw0, 32'd0);
      chk("midrst_no_dwrites", dw_a - dw0, 32'd0);
      reset_n = 1'b1;
      step();

      // Run 3: fresh start after the aborted run
      dw0 = dw_a;
      launch_a(24'h4B6579);
      wait_done_a();
      check_a(dw0, "run3");

      // Run 4: start with another key during keystream generation is ignored
      clear_a();
      dw0 = dw_a;
      launch_a(24'h4B6579);
      run_to(1796);
      key_a   = 24'h000000;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("run4_busy_after_start", {31'd0, busy_a}, 32'd1);
      wait_done_a();
      check_a(dw0, "run4");

      // Instance B: "Wiki" / "pedia"
      dw0     = dw_b;
      key_b   = 32'h57696B69;
      start_b = 1'b1;
      cyc     = 0;
      step();
      start_b = 1'b0;
      while (!done_b && cyc < 4000) step();
      chk("b_done_reached", {31'd0, done_b}, 32'd1);
      chk("b_done_cycle", cyc, B_DONE);
      chk("b_fail", {31'd0, fail_b}, 32'd0);
      chk("b_dwrites", dw_b - dw0, 32'd5);
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("b_d[%0d]", n), {24'd0, dmem_b[n]}, {24'd0, vb[n].pt});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
